// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue for OP, OP-IMM, LUI and AUIPC.
// Reads a 32x32 register file, tracks pending destinations in a scoreboard
// and presents ALU operands through a one-entry output register.
// Optional feature macro: ALU_ISSUE_BYPASS_EN (writeback-to-operand bypass).
module alu_issue_stage #(
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        illegal,
  output logic [31:0] illegal_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // Instruction fields
  logic [6:0]    ins_opc;
  logic [2:0]    ins_f3;
  logic [6:0]    ins_f7;
  logic [RW-1:0] ins_rs1;
  logic [RW-1:0] ins_rs2;
  logic [RW-1:0] ins_rd;

  assign ins_opc = in_instr[6:0];
  assign ins_f3  = in_instr[14:12];
  assign ins_f7  = in_instr[31:25];
  assign ins_rs1 = in_instr[19:15];
  assign ins_rs2 = in_instr[24:20];
  assign ins_rd  = in_instr[11:7];

  // State
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [6:0]      opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] illegal_pc_q, illegal_pc_d;

  // Decode
  logic            dec_legal, use_rs1, use_rs2;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [6:0]      dec_opc, dec_f7;
  logic [2:0]      dec_f3;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            byp_rs1, byp_rs2;
  logic            hazard, issue;

  // Source bypass from the writeback port when the source is pending
`ifdef ALU_ISSUE_BYPASS_EN
  assign byp_rs1 = wb_en && (wb_rd == ins_rs1) && (ins_rs1 != '0) && pending_q[ins_rs1];
  assign byp_rs2 = wb_en && (wb_rd == ins_rs2) && (ins_rs2 != '0) && pending_q[ins_rs2];
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  // Register file read with x0 forced to zero
  always_comb begin
    rs1_val = rf_q[ins_rs1];
    rs2_val = rf_q[ins_rs2];
    if (byp_rs1)          rs1_val = wb_data;
    if (byp_rs2)          rs2_val = wb_data;
    if (ins_rs1 == '0)    rs1_val = '0;
    if (ins_rs2 == '0)    rs2_val = '0;
  end

  // Legality check and operand/function mapping
  always_comb begin
    dec_legal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_a     = '0;
    dec_b     = '0;
    dec_opc   = ins_opc;
    dec_f3    = ins_f3;
    dec_f7    = ins_f7;
    case (ins_opc)
      OPC_OP: begin
        dec_legal = (ins_f7 == F7_ZERO) ||
                    ((ins_f7 == F7_ALT) && ((ins_f3 == 3'b000) || (ins_f3 == 3'b101)));
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_a     = rs1_val;
        dec_b     = rs2_val;
      end
      OPC_OPIMM: begin
        if (ins_f3 == 3'b001)      dec_legal = (ins_f7 == F7_ZERO);
        else if (ins_f3 == 3'b101) dec_legal = (ins_f7 == F7_ZERO) || (ins_f7 == F7_ALT);
        else                       dec_legal = 1'b1;
        use_rs1   = 1'b1;
        dec_a     = rs1_val;
        dec_b     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_opc   = OPC_OPIMM;
        dec_f3    = 3'b000;
        dec_f7    = F7_ZERO;
        dec_a     = (ins_opc == OPC_AUIPC) ? in_pc : '0;
        dec_b     = {in_instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // RAW hazard against pending sources and the resulting handshake
  always_comb begin
    hazard = (use_rs1 && pending_q[ins_rs1] && !byp_rs1) ||
             (use_rs2 && pending_q[ins_rs2] && !byp_rs2);
    in_ready = dec_legal ? ((!out_valid_q || out_ready) && !hazard) : 1'b1;
    issue    = in_valid && dec_legal && in_ready;
  end

  // Next-state: scoreboard, output register, illegal capture, register file
  always_comb begin
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    a_d          = a_q;
    b_d          = b_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    rd_d         = rd_q;
    illegal_d    = in_valid && !dec_legal;
    illegal_pc_d = illegal_pc_q;
    rf_d         = rf_q;

    if (wb_en) pending_d[wb_rd] = 1'b0;
    if (issue && (ins_rd != '0)) pending_d[ins_rd] = 1'b1;
    pending_d[0] = 1'b0;

    if (issue) begin
      out_valid_d = 1'b1;
      a_d         = dec_a;
      b_d         = dec_b;
      opcode_d    = dec_opc;
      funct3_d    = dec_f3;
      funct7_d    = dec_f7;
      rd_d        = ins_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (illegal_d) illegal_pc_d = in_pc;

    if (wb_en && (wb_rd != '0)) rf_d[wb_rd] = wb_data;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
      illegal_pc_q <= '0;
    end else begin
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      rd_q         <= rd_d;
      illegal_q    <= illegal_d;
      illegal_pc_q <= illegal_pc_d;
    end
  end

  // Register file; a writeback during reset is always dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (RF_RESET) rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign a          = a_q;
  assign b          = b_q;
  assign opcode     = opcode_q;
  assign funct3     = funct3_q;
  assign funct7     = funct7_q;
  assign rd         = rd_q;
  assign illegal    = illegal_q;
  assign illegal_pc = illegal_pc_q;

endmodule
